// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the halfword fetch sequencer.
// The state encoding and instruction-format helpers live here.
package fetch_sequencer_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FIRST  = 2'd1,
      S_SECOND = 2'd2,
      S_OUT    = 2'd3
   } state_t;

   localparam int INSN32_BIT = 15;
   localparam int HALF_W     = 16;
   localparam int INSN_W     = 32;

   function automatic logic is_insn32(input logic [HALF_W-1:0] half);
      return half[INSN32_BIT];
   endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetches 16-bit halfwords and assembles 16/32-bit instructions for the decoder.
// One outstanding memory request at a time; redirects drop any in-flight response.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int                  PC_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   output logic                o_imem_req,
   output logic [PC_WIDTH-1:0] o_imem_addr,
   input  logic                i_imem_valid,
   input  logic [HALF_W-1:0]   i_imem_rdata,
   input  logic                i_redirect,
   input  logic [PC_WIDTH-1:0] i_redirect_pc,
   output logic [INSN_W-1:0]   o_fetchoutput,
   output logic                o_fetch_valid,
   output logic [PC_WIDTH-1:0] o_fetch_pc,
   input  logic                i_decode_ready
);

   logic                r_rst_sync;
   logic                w_rst_n;
   state_t              r_state,       w_state_next;
   logic [PC_WIDTH-1:0] r_pc,          w_pc_next;
   logic [HALF_W-1:0]   r_hi,          w_hi_next;
   logic [INSN_W-1:0]   r_fetchoutput, w_fetchoutput_next;
   logic                r_fetch_valid, w_fetch_valid_next;
   logic [PC_WIDTH-1:0] r_fetch_pc,    w_fetch_pc_next;
   logic                r_pending,     w_pending_next;
   logic                r_drop,        w_drop_next;
   logic                w_req;
   logic                w_resp_ok;

   // Reset asserts immediately but releases on a clock edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_rst_sync <= 1'b0;
      else          r_rst_sync <= 1'b1;
   end
   assign w_rst_n = r_rst_sync;

   always_comb begin
      w_req = 1'b0;
      if ((r_state == S_FIRST || r_state == S_SECOND) && !r_pending && !i_redirect)
         w_req = 1'b1;
   end

   // Data is usable only if we asked for it, it is not stale, and no redirect is landing.
   assign w_resp_ok = i_imem_valid && r_pending && !r_drop && !i_redirect;

   always_comb begin
      w_state_next       = r_state;
      w_pc_next          = r_pc;
      w_hi_next          = r_hi;
      w_fetchoutput_next = r_fetchoutput;
      w_fetch_valid_next = r_fetch_valid;
      w_fetch_pc_next    = r_fetch_pc;
      w_pending_next     = r_pending;
      w_drop_next        = r_drop;

      if (w_req)             w_pending_next = 1'b1;
      else if (i_imem_valid) w_pending_next = 1'b0;

      if (i_imem_valid) w_drop_next = 1'b0;
      if (i_redirect && r_pending && !i_imem_valid) w_drop_next = 1'b1;

      if (i_redirect) begin
         w_pc_next          = i_redirect_pc;
         w_fetch_valid_next = 1'b0;
         w_state_next       = S_FIRST;
         w_hi_next          = '0;
      end else begin
         case (r_state)
            S_IDLE: w_state_next = S_FIRST;
            S_FIRST: begin
               if (w_resp_ok) begin
                  w_fetch_pc_next = r_pc;
                  w_pc_next       = r_pc + PC_WIDTH'(1);
                  if (is_insn32(i_imem_rdata)) begin
                     w_hi_next    = i_imem_rdata;
                     w_state_next = S_SECOND;
                  end else begin
                     w_fetchoutput_next = {i_imem_rdata, 16'h0000};
                     w_fetch_valid_next = 1'b1;
                     w_state_next       = S_OUT;
                  end
               end
            end
            S_SECOND: begin
               if (w_resp_ok) begin
                  w_fetchoutput_next = {r_hi, i_imem_rdata};
                  w_fetch_valid_next = 1'b1;
                  w_pc_next          = r_pc + PC_WIDTH'(1);
                  w_state_next       = S_OUT;
               end
            end
            S_OUT: begin
               if (r_fetch_valid && i_decode_ready) begin
                  w_fetch_valid_next = 1'b0;
                  w_state_next       = S_FIRST;
               end
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_hi          <= '0;
         r_fetchoutput <= '0;
         r_fetch_valid <= 1'b0;
         r_fetch_pc    <= '0;
         r_pending     <= 1'b0;
         r_drop        <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_pc          <= w_pc_next;
         r_hi          <= w_hi_next;
         r_fetchoutput <= w_fetchoutput_next;
         r_fetch_valid <= w_fetch_valid_next;
         r_fetch_pc    <= w_fetch_pc_next;
         r_pending     <= w_pending_next;
         r_drop        <= w_drop_next;
      end
   end

   assign o_imem_req    = w_req;
   assign o_imem_addr   = r_pc;
   assign o_fetchoutput = r_fetchoutput;
   assign o_fetch_valid = r_fetch_valid;
   assign o_fetch_pc    = r_fetch_pc;

endmodule
